result_bus_arbiter: RTL and testbench
=====================================

Name: result_bus_arbiter

Overview:
- Transmit side of the result-bus protocol. Each cycle it selects up to BUS_COUNT completed reservation stations and broadcasts their results on the result buses as (asserted, source, value). Every reservation station's bus snoop logic consumes these buses.
- It pulses set_unoccupied back to each granted station. The station therefore frees exactly once, in the cycle after the grant.
- It sits between the station array and the buses, in the core's execute stage.

Parameters:
- SIZE, 32: result value width.
- STATION_COUNT, 4: number of stations arbitrated. Station i broadcasts with source index i.
- STATION_INDEX_SIZE, 2: width of the source tag. Requires STATION_COUNT <= 2**STATION_INDEX_SIZE.
- BUS_COUNT, 2: number of result buses. Requires 1 <= BUS_COUNT <= STATION_COUNT.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- flush  input  1  discard: no grants this cycle; buses idle next cycle
- station_occupied  input  STATION_COUNT  bit i = station i occupied
- station_result_ready  input  STATION_COUNT  bit i = station i result valid
- station_result  input  STATION_COUNT*SIZE  station i result at bits [i*SIZE +: SIZE]
- set_unoccupied  output  STATION_COUNT  combinational grant pulse to station i
- bus_asserted  output  BUS_COUNT  registered; bus k carries a valid result
- bus_source  output  BUS_COUNT*STATION_INDEX_SIZE  registered; bus k tag at [k*STATION_INDEX_SIZE +: STATION_INDEX_SIZE]
- bus_value  output  BUS_COUNT*SIZE  registered; bus k value at [k*SIZE +: SIZE]

Behaviour:
- Request definition: request[i] = station_occupied[i] && station_result_ready[i]. Unoccupied stations never request, even if result_ready is high.
- Grant selection (combinational, cycle t):
  - Scan stations in priority order and grant the first min(BUS_COUNT, popcount(request)) requesters.
  - The k-th grant in scan order goes to bus k. Unused buses are the highest-numbered buses.
- set_unoccupied[i] is high in cycle t iff station i is granted in cycle t and flush=0 and reset=0. Otherwise it is 0.
- Broadcast latency is exactly one cycle: at the posedge ending cycle t, bus k registers for cycle t+1 as follows.
  - Granted bus: bus_asserted[k]=1, bus_source[k]=i, bus_value[k]=station_result[i] as sampled in cycle t.
  - Ungranted bus: bus_asserted[k]=0. bus_source and bus_value are held at their previous values.
- No double broadcast: a station granted in cycle t sees occupied=0 in cycle t+1 and cannot request again. Dispatch never loads an occupied station, so load and set_unoccupied never coincide on one station.
- Buses are not backpressured. Every bus_asserted pulse is a one-cycle broadcast.
- flush=1 in cycle t: no set_unoccupied, all bus_asserted=0 in cycle t+1, priority pointer unchanged.
- reset=1: takes priority over flush and grants. Next cycle all outputs are as follows.
  - bus_asserted=0, bus_source=0, bus_value=0.
  - Pointer = 0.
  - set_unoccupied=0 while reset is high.
- Reset mid-broadcast: a bus asserted in the reset cycle drops to 0 the next cycle.
- Boundary cases:
  - No requesters: all buses deassert; pointer unchanged.
  - More requesters than buses: excess requesters wait, holding their results, and are served in later cycles.
  - Requests exactly equal to BUS_COUNT: all are granted in the same cycle.

Optional Feature:
- Macro: RESULT_BUS_ARB_FAIR_EN.
- Defined (round-robin):
  - A register rr_ptr of STATION_INDEX_SIZE bits sets the scan start. Scan order is rr_ptr, rr_ptr+1, ... STATION_COUNT-1, 0, ... with wrap modulo STATION_COUNT.
  - After a cycle with at least one grant and no flush, rr_ptr <= (index of last granted station + 1) mod STATION_COUNT.
  - Otherwise rr_ptr is unchanged.
- Undefined (fixed priority): scan order is always 0..STATION_COUNT-1, and no pointer register exists.
- Bus k assignment order follows the scan order in both modes.

Test Plan:
- Reset, then idle: hold reset 2 cycles, requests 0 -> bus_asserted=00, bus_source=0, bus_value=0, set_unoccupied=0000.
- Single requester: station 2 occupied+ready with result 0x0000_0055 in cycle t -> set_unoccupied=0100 in t; in t+1 bus_asserted=01, bus0 source=2, value=0x55; station model frees, so there is no repeat in t+2.
- Oversubscription, fixed mode: all 4 stations request with results 0x10, 0x11, 0x12, 0x13 -> cycle 1 buses carry (0,0x10), (1,0x11); cycle 2 buses carry (2,0x12), (3,0x13); cycle 3 bus_asserted=00.
- Round-robin with RESULT_BUS_ARB_FAIR_EN defined: stations 0 and 3 request continuously (re-occupied after each free), BUS_COUNT=1 -> grants alternate 0, 3, 0, 3; rr_ptr wraps from 3+1 to 0 -> 0 is correct.
- Ready but unoccupied: station 1 has ready=1 and occupied=0 -> never granted, buses idle.
- Flush and reset collision: stations 0 and 1 request while flush=1 -> set_unoccupied=0000 and buses idle the next cycle; next cycle with flush=0 they are granted normally. With reset and flush both high, reset values apply.

Source files
------------

// File: rtl/result_bus_arbiter_if.sv
// Result-bus arbiter port bundle: station-array requests in, grant pulses and
// registered result-bus broadcasts out. The arbiter uses master; stations/bench use slave.
interface result_bus_arbiter_if #(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = 2,
  parameter int BUS_COUNT          = 2
);

  logic                                    flush;
  logic [STATION_COUNT-1:0]                station_occupied;
  logic [STATION_COUNT-1:0]                station_result_ready;
  logic [STATION_COUNT*SIZE-1:0]           station_result;
  logic [STATION_COUNT-1:0]                set_unoccupied;
  logic [BUS_COUNT-1:0]                    bus_asserted;
  logic [BUS_COUNT*STATION_INDEX_SIZE-1:0] bus_source;
  logic [BUS_COUNT*SIZE-1:0]               bus_value;

  modport master (
    input  flush,
    input  station_occupied,
    input  station_result_ready,
    input  station_result,
    output set_unoccupied,
    output bus_asserted,
    output bus_source,
    output bus_value
  );

  modport slave (
    output flush,
    output station_occupied,
    output station_result_ready,
    output station_result,
    input  set_unoccupied,
    input  bus_asserted,
    input  bus_source,
    input  bus_value
  );

endinterface

// File: rtl/result_bus_arbiter.sv
// Result-bus transmit arbiter: grants up to BUS_COUNT ready stations per cycle and
// broadcasts them one cycle later. Define RESULT_BUS_ARB_FAIR_EN for round-robin scan order.
module result_bus_arbiter #(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = 2,
  parameter int BUS_COUNT          = 2
) (
  input logic                  clock,
  input logic                  reset,
  result_bus_arbiter_if.master rb
);

  localparam int SC  = STATION_COUNT;
  localparam int SIS = STATION_INDEX_SIZE;
  localparam int BC  = BUS_COUNT;

  if (SC > (1 << SIS) || BC < 1 || BC > SC) begin : g_bad_params
    $error("result_bus_arbiter: illegal STATION_COUNT/STATION_INDEX_SIZE/BUS_COUNT combination");
  end

  logic [SC-1:0]       request;
  logic [SC-1:0]       grant;
  logic                any_grant;
  logic [SIS-1:0]      last_grant;
  logic [SIS-1:0]      scan_start;

  logic [BC-1:0]       bus_asserted_q, bus_asserted_d;
  logic [BC*SIS-1:0]   bus_source_q,   bus_source_d;
  logic [BC*SIZE-1:0]  bus_value_q,    bus_value_d;

`ifdef RESULT_BUS_ARB_FAIR_EN
  logic [SIS-1:0]      rr_ptr_q, rr_ptr_d;
  assign scan_start = rr_ptr_q;
`else
  assign scan_start = '0;
`endif

  assign request = rb.station_occupied & rb.station_result_ready;

  // Walk stations from scan_start with wrap; the k-th requester found lands on bus k.
  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    int slot;
    int idx;
    grant          = '0;
    any_grant      = 1'b0;
    last_grant     = '0;
    bus_asserted_d = '0;
    bus_source_d   = bus_source_q;
    bus_value_d    = bus_value_q;
    slot           = 0;
    idx            = 0;
    for (int j = 0; j < SC; j++) begin
      idx = int'(scan_start) + j;
      if (idx >= SC) idx = idx - SC;
      if (request[idx] && slot < BC) begin
        grant[idx]                     = 1'b1;
        any_grant                      = 1'b1;
        last_grant                     = SIS'(idx);
        bus_asserted_d[slot]           = 1'b1;
        bus_source_d[slot*SIS +: SIS]  = SIS'(idx);
        bus_value_d[slot*SIZE +: SIZE] = rb.station_result[idx*SIZE +: SIZE];
        slot                           = slot + 1;
      end
    end
    // Flush and reset squash the whole cycle: no frees, idle buses, tags/values held.
    if (reset || rb.flush) begin
      grant          = '0;
      any_grant      = 1'b0;
      bus_asserted_d = '0;
      bus_source_d   = bus_source_q;
      bus_value_d    = bus_value_q;
    end
  end

`ifdef RESULT_BUS_ARB_FAIR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (int'(last_grant) + 1 >= SC) ? '0 : last_grant + 1'b1;
    end
  end
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_asserted_q <= '0;
      bus_source_q   <= '0;
      bus_value_q    <= '0;
`ifdef RESULT_BUS_ARB_FAIR_EN
      rr_ptr_q       <= '0;
`endif
    end else begin
      bus_asserted_q <= bus_asserted_d;
      bus_source_q   <= bus_source_d;
      bus_value_q    <= bus_value_d;
`ifdef RESULT_BUS_ARB_FAIR_EN
      rr_ptr_q       <= rr_ptr_d;
`endif
    end
  end

  assign rb.set_unoccupied = grant;
  assign rb.bus_asserted   = bus_asserted_q;
  assign rb.bus_source     = bus_source_q;
  assign rb.bus_value      = bus_value_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench for result_bus_arbiter: per-cycle expected bus state is queued at drive
// time and compared after the edge; scenario tasks add fixed-value checks.
module tb_result_bus_arbiter;

  localparam int SIZE = 32;
  localparam int SC   = 4;
  localparam int SIS  = 2;
`ifdef RESULT_BUS_ARB_FAIR_EN
  localparam int BC   = 1;
  localparam bit FAIR = 1'b1;
`else
  localparam int BC   = 2;
  localparam bit FAIR = 1'b0;
`endif

  typedef struct packed {
    logic [BC-1:0]      asserted;
    logic [BC*SIS-1:0]  source;
    logic [BC*SIZE-1:0] value;
  } bus_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   mdl_ptr  = 0;
  bus_t held     = '0;
  bus_t exp_q[$];

  always #5 clock = ~clock;

  result_bus_arbiter_if #(.SIZE(SIZE), .STATION_COUNT(SC), .STATION_INDEX_SIZE(SIS),
                          .BUS_COUNT(BC)) rb ();

  result_bus_arbiter #(.SIZE(SIZE), .STATION_COUNT(SC), .STATION_INDEX_SIZE(SIS),
                       .BUS_COUNT(BC)) dut (
    .clock (clock),
    .reset (reset),
    .rb    (rb)
  );

  // One clock of the station/bus model: predict grants, queue next bus state, compare both.
  task automatic run_cycle(output logic [SC-1:0] grant);
    logic [SC-1:0] req;
    bus_t nxt, got, want;
    int n, last, idx;
    req        = rb.station_occupied & rb.station_result_ready;
    grant      = '0;
    nxt        = held;
    nxt.asserted = '0;
    n          = 0;
    last       = -1;
    if (reset) begin
      nxt = '0;
    end else if (!rb.flush) begin
      for (int j = 0; j < SC; j++) begin
        idx = (mdl_ptr + j) % SC;
        if (req[idx] && n < BC) begin
          grant[idx]                 = 1'b1;
          nxt.asserted[n]            = 1'b1;
          nxt.source[n*SIS +: SIS]   = SIS'(idx);
          nxt.value[n*SIZE +: SIZE]  = rb.station_result[idx*SIZE +: SIZE];
          last = idx;
          n++;
        end
      end
    end
    exp_q.push_back(nxt);
    @(negedge clock);
    checks++;
    if (rb.set_unoccupied !== grant) begin
      failures++;
      $display("FAIL set_unoccupied got=%b want=%b t=%0t", rb.set_unoccupied, grant, $time);
    end
    @(posedge clock);
    #1;
    got  = {rb.bus_asserted, rb.bus_source, rb.bus_value};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL bus_state got=%b/%h/%h want=%b/%h/%h t=%0t", got.asserted, got.source,
               got.value, want.asserted, want.source, want.value, $time);
    end
    held = want;
    if (reset) mdl_ptr = 0;
    else if (last >= 0 && FAIR) mdl_ptr = (last + 1) % SC;
    rb.station_occupied = rb.station_occupied & ~grant;
  endtask

  task automatic test_reset();
    logic [SC-1:0] g;
    reset = 1'b1;
    rb.station_occupied     = '0;
    rb.station_result_ready = '0;
    run_cycle(g);
    run_cycle(g);
    reset = 1'b0;
    #1;
    checks++;
    if (rb.bus_asserted !== '0) begin
      failures++; $display("FAIL reset_asserted got=%b want=0", rb.bus_asserted);
    end
    checks++;
    if (rb.bus_source !== '0) begin
      failures++; $display("FAIL reset_source got=%h want=0", rb.bus_source);
    end
    checks++;
    if (rb.bus_value !== '0) begin
      failures++; $display("FAIL reset_value got=%h want=0", rb.bus_value);
    end
    checks++;
    if (rb.set_unoccupied !== '0) begin
      failures++; $display("FAIL reset_set_unoccupied got=%b want=0", rb.set_unoccupied);
    end
  endtask

  task automatic test_single();
    logic [SC-1:0] g;
    rb.station_result[2*SIZE +: SIZE] = 32'h0000_0055;
    rb.station_occupied     = 4'b0100;
    rb.station_result_ready = 4'b0100;
    run_cycle(g);
    checks++;
    if (rb.bus_asserted !== BC'(1)) begin
      failures++; $display("FAIL single_asserted got=%b want=%b", rb.bus_asserted, BC'(1));
    end
    checks++;
    if (rb.bus_source[SIS-1:0] !== 2'd2) begin
      failures++; $display("FAIL single_source got=%0d want=2", rb.bus_source[SIS-1:0]);
    end
    checks++;
    if (rb.bus_value[SIZE-1:0] !== 32'h55) begin
      failures++; $display("FAIL single_value got=%h want=55", rb.bus_value[SIZE-1:0]);
    end
    run_cycle(g);
    checks++;
    if (rb.bus_asserted !== '0) begin
      failures++; $display("FAIL single_no_repeat got=%b want=0", rb.bus_asserted);
    end
    rb.station_result_ready = '0;
  endtask

  task automatic test_unoccupied();
    logic [SC-1:0] g;
    rb.station_occupied     = '0;
    rb.station_result_ready = 4'b0010;
    rb.station_result[1*SIZE +: SIZE] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      run_cycle(g);
      checks++;
      if (rb.bus_asserted !== '0) begin
        failures++; $display("FAIL unoccupied_idle got=%b want=0", rb.bus_asserted);
      end
    end
    rb.station_result_ready = '0;
  endtask

  task automatic test_flush_reset();
    logic [SC-1:0] g;
    rb.station_result[0*SIZE +: SIZE] = 32'hA0;
    rb.station_result[1*SIZE +: SIZE] = 32'hA1;
    rb.station_occupied     = 4'b0011;
    rb.station_result_ready = 4'b0011;
    rb.flush = 1'b1;
    run_cycle(g);
    checks++;
    if (rb.bus_asserted !== '0) begin
      failures++; $display("FAIL flush_idle got=%b want=0", rb.bus_asserted);
    end
    rb.flush = 1'b0;
    run_cycle(g);
    checks++;
    if (rb.bus_asserted[0] !== 1'b1 || rb.bus_source[SIS-1:0] !== 2'd0 ||
        rb.bus_value[SIZE-1:0] !== 32'hA0) begin
      failures++;
      $display("FAIL after_flush_bus0 got=%b/%0d/%h want=1/0/a0", rb.bus_asserted[0],
               rb.bus_source[SIS-1:0], rb.bus_value[SIZE-1:0]);
    end
    rb.station_occupied = 4'b0011;
    reset    = 1'b1;
    rb.flush = 1'b1;
    run_cycle(g);
    reset    = 1'b0;
    rb.flush = 1'b0;
    checks++;
    if (rb.bus_asserted !== '0 || rb.bus_source !== '0 || rb.bus_value !== '0) begin
      failures++;
      $display("FAIL reset_flush got=%b/%h/%h want=0/0/0", rb.bus_asserted, rb.bus_source,
               rb.bus_value);
    end
    rb.station_occupied     = '0;
    rb.station_result_ready = '0;
  endtask

`ifdef RESULT_BUS_ARB_FAIR_EN
  task automatic test_round_robin();
    logic [SC-1:0] g;
    int exp_src[4] = '{0, 3, 0, 3};
    reset = 1'b1;
    run_cycle(g);
    reset = 1'b0;
    rb.station_result[0*SIZE +: SIZE] = 32'h30;
    rb.station_result[3*SIZE +: SIZE] = 32'h33;
    rb.station_occupied     = 4'b1001;
    rb.station_result_ready = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      run_cycle(g);
      checks++;
      if (rb.bus_asserted !== 1'b1 || rb.bus_source[SIS-1:0] !== SIS'(exp_src[i])) begin
        failures++;
        $display("FAIL rr_order step=%0d got=%b/%0d want=1/%0d", i, rb.bus_asserted,
                 rb.bus_source[SIS-1:0], exp_src[i]);
      end
      rb.station_occupied = rb.station_occupied | 4'b1001;
    end
    rb.station_occupied     = '0;
    rb.station_result_ready = '0;
    run_cycle(g);
  endtask
`else
  task automatic test_oversub();
    logic [SC-1:0] g;
    for (int i = 0; i < SC; i++) rb.station_result[i*SIZE +: SIZE] = 32'h10 + i;
    rb.station_occupied     = 4'b1111;
    rb.station_result_ready = 4'b1111;
    run_cycle(g);
    checks++;
    if (rb.bus_asserted !== 2'b11 || rb.bus_source !== {2'd1, 2'd0} ||
        rb.bus_value !== {32'h11, 32'h10}) begin
      failures++;
      $display("FAIL oversub_cycle1 got=%b/%h/%h want=11/4/0000001100000010", rb.bus_asserted,
               rb.bus_source, rb.bus_value);
    end
    run_cycle(g);
    checks++;
    if (rb.bus_asserted !== 2'b11 || rb.bus_source !== {2'd3, 2'd2} ||
        rb.bus_value !== {32'h13, 32'h12}) begin
      failures++;
      $display("FAIL oversub_cycle2 got=%b/%h/%h want=11/e/0000001300000012", rb.bus_asserted,
               rb.bus_source, rb.bus_value);
    end
    run_cycle(g);
    checks++;
    if (rb.bus_asserted !== 2'b00) begin
      failures++; $display("FAIL oversub_cycle3 got=%b want=00", rb.bus_asserted);
    end
    rb.station_result_ready = '0;
  endtask
`endif

  task automatic test_random();
    logic [SC-1:0] g;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < SC; i++) begin
        if (!rb.station_occupied[i] && $urandom_range(1, 0) == 1) begin
          rb.station_occupied[i] = 1'b1;
          rb.station_result[i*SIZE +: SIZE] = $urandom;
        end
      end
      rb.station_result_ready = SC'($urandom);
      rb.flush = ($urandom_range(9, 0) == 0);
      run_cycle(g);
    end
    rb.flush                = 1'b0;
    rb.station_occupied     = '0;
    rb.station_result_ready = '0;
    run_cycle(g);
  endtask

  initial begin
    rb.flush                = 1'b0;
    rb.station_occupied     = '0;
    rb.station_result_ready = '0;
    rb.station_result       = '0;
    test_reset();
    test_single();
    test_unoccupied();
    test_flush_reset();
`ifdef RESULT_BUS_ARB_FAIR_EN
    test_round_robin();
`else
    test_oversub();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
